byte_encode_stream: RTL

Sequential ByteEncode_d packer for the ML-KEM conversion path. It consumes one frame of N_COEFFS coefficients over a valid/ready stream and truncates each coefficient to d bits. It packs them LSB-first into a contiguous bit string and emits that string one byte at a time over a valid/ready stream. The byte ordering matches the combinational bits-to-bytes stage: bit k of the frame lands in byte k/8, bit position k%8.

---
 rtl/byte_encode_stream.sv | 121 ++++++++++++
 1 files changed

// File: rtl/byte_encode_stream.sv
// ByteEncode_d streaming packer: d-bit coefficients in, LSB-first packed bytes out.
// Optional sticky range check on input coefficients: define BYTE_ENCODE_RANGE_CHECK_EN.
module byte_encode_stream #(
  parameter int N_COEFFS = 256,
  parameter int COEF_W   = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [3:0]        d_i,
  input  logic [COEF_W-1:0] coef_i,
  input  logic              coef_valid_i,
  output logic              coef_ready_o,
  output logic [7:0]        byte_o,
  output logic              byte_valid_o,
  input  logic              byte_ready_i,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int BUF_W = 20;
  localparam int CC_W  = $clog2(N_COEFFS + 1);
  localparam int BC_W  = $clog2(N_COEFFS * COEF_W / 8 + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [BUF_W-1:0]  pack_buf;
  logic [4:0]        bit_cnt;
  logic [CC_W-1:0]   coef_cnt;
  logic [BC_W-1:0]   byte_cnt;
  logic [3:0]        d_q;

  logic              start_ok;
  logic              coef_fire;
  logic              byte_fire;
  logic [COEF_W-1:0] mask;
  logic [COEF_W-1:0] coef_trunc;
  logic [BUF_W-1:0]  ins;
  logic [BC_W-1:0]   frame_bytes;

  always_comb begin
    start_ok     = (state == IDLE) && start_i && (d_i != 4'd0) && (d_i <= 4'(COEF_W));
    coef_ready_o = (state == RUN) && (bit_cnt < 5'd8) && (coef_cnt < CC_W'(N_COEFFS));
    byte_valid_o = (state == RUN) && (bit_cnt >= 5'd8);
    coef_fire    = coef_valid_i && coef_ready_o;
    byte_fire    = byte_valid_o && byte_ready_i;
    // Bits above bit_cnt are always zero, so OR-ing the shifted coefficient in is a part-select write.
    mask         = ~({COEF_W{1'b1}} << d_q);
    coef_trunc   = coef_i & mask;
    ins          = BUF_W'(coef_trunc) << bit_cnt;
    frame_bytes  = BC_W'(N_COEFFS / 8) * BC_W'(d_q);
    last_o       = byte_valid_o && (byte_cnt == frame_bytes - BC_W'(1));
    byte_o       = pack_buf[7:0];
    busy_o       = (state == RUN);
    done_o       = (state == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      pack_buf <= '0;
      bit_cnt  <= '0;
      coef_cnt <= '0;
      byte_cnt <= '0;
      d_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            d_q      <= d_i;
            pack_buf <= '0;
            bit_cnt  <= '0;
            coef_cnt <= '0;
            byte_cnt <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (coef_fire) begin
            pack_buf <= pack_buf | ins;
            bit_cnt  <= bit_cnt + {1'b0, d_q};
            coef_cnt <= coef_cnt + CC_W'(1);
          end else if (byte_fire) begin
            pack_buf <= pack_buf >> 8;
            bit_cnt  <= bit_cnt - 5'd8;
            byte_cnt <= byte_cnt + BC_W'(1);
            if (last_o) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BYTE_ENCODE_RANGE_CHECK_EN
  logic err_q;
  logic range_bad;

  always_comb begin
    range_bad = ((d_q < 4'(COEF_W)) && ((coef_i & ~mask) != '0)) ||
                ((d_q == 4'd12) && (coef_i >= COEF_W'(3329)));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     err_q <= 1'b0;
    else if (start_ok)               err_q <= 1'b0;
    else if (coef_fire && range_bad) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
